ram_bus_ctrl: RTL



---
 rtl/ram_bus_pkg.sv | 56 +++++
 rtl/ram_bus_ld_align.sv | 25 ++
 rtl/ram_bus_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bus_pkg.sv
// ram_bus_pkg
// Shared definitions for the RAM bus controller and the LSU load path:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'd3 is illegal)
//   - controller FSM state type
//   - byte_en_gen     : byte-enable strobe for a size/offset pair
//   - wdata_replicate : lane replication of LSB-justified store data
//   - load_extend     : lane select plus sign/zero extension of a RAM word
package ram_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RSP     = 2'd3
    } state_t;

    function automatic logic [3:0] byte_en_gen(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be_s;
        case (size)
            SZ_BYTE: be_s = 4'b0001 << offset;
            SZ_HALF: be_s = 4'b0011 << offset;
            SZ_WORD: be_s = 4'b1111;
            default: be_s = 4'b0000;
        endcase
        return be_s;
    endfunction

    // Replicating the data across all lanes lets the byte enables alone pick the target lane.
    function automatic logic [31:0] wdata_replicate(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] rep_s;
        case (size)
            SZ_BYTE: rep_s = {4{wdata[7:0]}};
            SZ_HALF: rep_s = {2{wdata[15:0]}};
            default: rep_s = wdata;
        endcase
        return rep_s;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] offset,
                                                input logic [1:0] size, input logic is_unsigned);
        logic [31:0] shifted_s;
        logic [31:0] result_s;
        shifted_s = word >> {offset, 3'b000};
        case (size)
            SZ_BYTE: result_s = {{24{~is_unsigned & shifted_s[7]}}, shifted_s[7:0]};
            SZ_HALF: result_s = {{16{~is_unsigned & shifted_s[15]}}, shifted_s[15:0]};
            default: result_s = word;
        endcase
        return result_s;
    endfunction

endpackage

// File: rtl/ram_bus_ld_align.sv
// ram_bus_ld_align
// Combinational load alignment: selects the addressed byte/halfword lane of a
// 32-bit RAM word and sign- or zero-extends it. Shared with the LSU.
// Ports:
//   word        in  32  raw RAM word
//   offset      in  2   byte offset within the word
//   size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned in  1   zero-extend when 1, sign-extend when 0
//   data        out 32  aligned, extended load data
module ram_bus_ld_align
    import ram_bus_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    // Lane select and extension
    always_comb begin
        data = load_extend(word, offset, size, is_unsigned);
    end

endmodule

// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl
// Initiator-side controller for a single-port, byte-enabled 32-bit synchronous
// RAM. Accepts one load/store request at a time, drives the RAM strobes, waits
// out the read latency, aligns/extends load data and returns one response.
// ram_rd_data is expected to hold the addressed word RD_LATENCY clock edges
// after ram_addr changes.
// Optional build macro: RAM_BUS_CTRL_STORE_FWD_EN keeps a one-entry last-store
// shadow that is overlaid on load data hitting the same word (for RAMs whose
// read-after-write returns stale data).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_we/addr/wdata/size/unsigned request fields
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata/rsp_err               response payload
//   ram_addr/ram_wr_data/ram_wr_en/ram_wr_byte_en  RAM command (registered)
//   ram_rd_data                     RAM read data
module ram_bus_ctrl
    import ram_bus_pkg::*;
#(
    parameter int          ADDR_WIDTH = 13,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wr_data,
    output logic                  ram_wr_en,
    output logic [3:0]            ram_wr_byte_en,
    input  logic [31:0]           ram_rd_data
);

    state_t                state_r;
    logic                  req_ready_r;
    logic                  rsp_valid_r;
    logic [31:0]           rsp_rdata_r;
    logic                  rsp_err_r;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [31:0]           ram_wr_data_r;
    logic                  ram_wr_en_r;
    logic [3:0]            ram_wr_byte_en_r;

    // Request fields held for the whole transaction
    logic                  we_r;
    logic [1:0]            offset_r;
    logic [1:0]            size_r;
    logic                  uns_r;

    logic                  size_err_s;
    logic                  align_err_s;
    logic                  region_err_s;
    logic                  req_err_s;
    logic [31:0]           ld_word_s;
    logic [31:0]           ld_data_s;

    assign req_ready      = req_ready_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_rdata      = rsp_rdata_r;
    assign rsp_err        = rsp_err_r;
    assign ram_addr       = ram_addr_r;
    assign ram_wr_data    = ram_wr_data_r;
    assign ram_wr_en      = ram_wr_en_r;
    assign ram_wr_byte_en = ram_wr_byte_en_r;

    // Request decode: illegal size, misalignment and region check
    always_comb begin
        size_err_s = (req_size == 2'd3);
        case (req_size)
            SZ_HALF: align_err_s = req_addr[0];
            SZ_WORD: align_err_s = (req_addr[1:0] != 2'b00);
            default: align_err_s = 1'b0;
        endcase
        region_err_s = (req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);
        req_err_s    = size_err_s | align_err_s | region_err_s;
    end

`ifdef RAM_BUS_CTRL_STORE_FWD_EN
    logic                  shadow_valid_r;
    logic [ADDR_WIDTH-1:0] shadow_addr_r;
    logic [31:0]           shadow_data_r;
    logic [3:0]            shadow_be_r;

    // Remember the strobes of the store currently being written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_valid_r <= 1'b0;
            shadow_addr_r  <= {ADDR_WIDTH{1'b0}};
            shadow_data_r  <= 32'h0;
            shadow_be_r    <= 4'b0000;
        end else if (state_r == ST_ACCESS && we_r) begin
            shadow_valid_r <= 1'b1;
            shadow_addr_r  <= ram_addr_r;
            shadow_data_r  <= ram_wr_data_r;
            shadow_be_r    <= ram_wr_byte_en_r;
        end else begin
            shadow_valid_r <= shadow_valid_r;
            shadow_addr_r  <= shadow_addr_r;
            shadow_data_r  <= shadow_data_r;
            shadow_be_r    <= shadow_be_r;
        end
    end

    // Overlay the shadowed store bytes on a load to the same word
    always_comb begin
        ld_word_s = ram_rd_data;
        for (int b = 0; b < 4; b++) begin
            if (shadow_valid_r && (shadow_addr_r == ram_addr_r) && shadow_be_r[b]) begin
                ld_word_s[b*8 +: 8] = shadow_data_r[b*8 +: 8];
            end else begin
                ld_word_s[b*8 +: 8] = ram_rd_data[b*8 +: 8];
            end
        end
    end
`else
    assign ld_word_s = ram_rd_data;
`endif

    ram_bus_ld_align u_ld_align (
        .word        (ld_word_s),
        .offset      (offset_r),
        .size        (size_r),
        .is_unsigned (uns_r),
        .data        (ld_data_s)
    );

    // Transaction FSM with registered response and RAM command outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            req_ready_r      <= 1'b0;
            rsp_valid_r      <= 1'b0;
            rsp_rdata_r      <= 32'h0;
            rsp_err_r        <= 1'b0;
            ram_addr_r       <= {ADDR_WIDTH{1'b0}};
            ram_wr_data_r    <= 32'h0;
            ram_wr_en_r      <= 1'b0;
            ram_wr_byte_en_r <= 4'b0000;
            we_r             <= 1'b0;
            offset_r         <= 2'b00;
            size_r           <= SZ_BYTE;
            uns_r            <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ram_wr_en_r <= 1'b0;
                    // req_ready rises one cycle after reset release, so a request
                    // is only taken once the registered ready is visible.
                    if (req_valid && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        we_r        <= req_we;
                        offset_r    <= req_addr[1:0];
                        size_r      <= req_size;
                        uns_r       <= req_unsigned;
                        if (req_err_s) begin
                            state_r     <= ST_RSP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= 32'h0;
                        end else begin
                            state_r    <= ST_ACCESS;
                            ram_addr_r <= req_addr[ADDR_WIDTH+1:2];
                            if (req_we) begin
                                ram_wr_en_r      <= 1'b1;
                                ram_wr_byte_en_r <= byte_en_gen(req_size, req_addr[1:0]);
                                ram_wr_data_r    <= wdata_replicate(req_size, req_wdata);
                            end else begin
                                ram_wr_en_r <= 1'b0;
                            end
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    ram_wr_en_r <= 1'b0;
                    if (we_r) begin
                        state_r     <= ST_RSP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= 32'h0;
                    end else if (RD_LATENCY == 1) begin
                        state_r     <= ST_RSP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= ld_data_s;
                    end else begin
                        state_r <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    state_r     <= ST_RSP;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= ld_data_s;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end else begin
                        state_r     <= ST_RSP;
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b0;
                    ram_wr_en_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
